pipelined_sparse_sum_generator: RTL and testbench

//  Downstream stage of the 4-sparse Sklansky carry generator. Consumes its

---
 rtl/pipelined_sparse_sum_generator.sv | 111 +++++++++++
 tb/tb_pipelined_sparse_sum_generator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_sparse_sum_generator.sv
// Two-stage valid/ready carry-select sum builder for the 4-sparse carry generator.
// S1 registers per-group conditional sums and carries; S2 selects with the sparse carries.
module pipelined_sparse_sum_generator #(
  parameter int N_BIT = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BIT-1:0]   operand_1,
  input  logic [N_BIT-1:0]   operand_2,
  input  logic               carry_in,
  input  logic [N_BIT/4-1:0] sparse_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_BIT-1:0]   sum,
  output logic               carry_out,
  output logic               overflow
);

  localparam int N_GRP = N_BIT / 4;

  logic                       s1_en;
  logic                       s2_en;
  logic                       s1_valid;
  logic                       s1_cin;
  logic [N_GRP-1:0]           s1_sc;
  logic [N_GRP-1:0][3:0]      s1_s0;
  logic [N_GRP-1:0][3:0]      s1_s1;
  logic                       s1_msb_c0;
  logic                       s1_msb_c1;

  logic [N_GRP-1:0][3:0]      grp_s0;
  logic [N_GRP-1:0][3:0]      grp_s1;
  logic [3:0]                 hi3_c0;
  logic [3:0]                 hi3_c1;

  logic [N_GRP-1:0]           grp_sel;
  logic [N_BIT-1:0]           nxt_sum;
  logic                       nxt_co;
  logic                       nxt_ov;
  logic                       msb_cin;

  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  // Conditional group sums; bits N_BIT-4..N_BIT-2 also give the carry into the MSB.
  always_comb begin
    grp_s0 = '0;
    grp_s1 = '0;
    for (int g = 0; g < N_GRP; g++) begin
      grp_s0[g] = operand_1[4*g +: 4] + operand_2[4*g +: 4];
      grp_s1[g] = operand_1[4*g +: 4] + operand_2[4*g +: 4] + 4'd1;
    end
    hi3_c0 = {1'b0, operand_1[N_BIT-2 -: 3]} + {1'b0, operand_2[N_BIT-2 -: 3]};
    hi3_c1 = {1'b0, operand_1[N_BIT-2 -: 3]} + {1'b0, operand_2[N_BIT-2 -: 3]} + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_cin    <= 1'b0;
      s1_sc     <= '0;
      s1_s0     <= '0;
      s1_s1     <= '0;
      s1_msb_c0 <= 1'b0;
      s1_msb_c1 <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cin    <= carry_in;
        s1_sc     <= sparse_carry;
        s1_s0     <= grp_s0;
        s1_s1     <= grp_s1;
        s1_msb_c0 <= hi3_c0[3];
        s1_msb_c1 <= hi3_c1[3];
      end
    end
  end

  // Group g is selected by the carry into its LSB: carry_in for g=0, else sparse_carry[g-1].
  assign grp_sel = {s1_sc[N_GRP-2:0], s1_cin};

  always_comb begin
    nxt_sum = '0;
    for (int g = 0; g < N_GRP; g++) begin
      nxt_sum[4*g +: 4] = grp_sel[g] ? s1_s1[g] : s1_s0[g];
    end
    nxt_co  = s1_sc[N_GRP-1];
    msb_cin = grp_sel[N_GRP-1] ? s1_msb_c1 : s1_msb_c0;
    nxt_ov  = msb_cin ^ nxt_co;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum       <= nxt_sum;
        carry_out <= nxt_co;
        overflow  <= nxt_ov;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_sparse_sum_generator.sv
// Directed and random checks of the sparse-carry sum pipeline at N_BIT=32 and N_BIT=8.
// Expected results come from hand-computed constants and a plain A+B+cin reference.
module tb_pipelined_sparse_sum_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;

  logic        in_ready;
  logic [31:0] op1 = '0, op2 = '0;
  logic [7:0]  sc32 = '0;
  logic        out_valid;
  logic [31:0] sum;
  logic        co, ov;

  logic        in_ready8;
  logic [7:0]  op1_8 = '0, op2_8 = '0;
  logic [1:0]  sc8 = '0;
  logic        out_valid8;
  logic [7:0]  sum8;
  logic        co8, ov8;

  int n_tests = 0;
  int n_fail  = 0;

  logic [33:0] q32[$];
  logic [9:0]  q8[$];

  always #5 clock = ~clock;

  pipelined_sparse_sum_generator #(.N_BIT(32)) dut32 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand_1(op1), .operand_2(op2), .carry_in(cin), .sparse_carry(sc32),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(co), .overflow(ov)
  );

  pipelined_sparse_sum_generator #(.N_BIT(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .operand_1(op1_8), .operand_2(op2_8), .carry_in(cin), .sparse_carry(sc8),
    .out_valid(out_valid8), .out_ready(out_ready), .sum(sum8),
    .carry_out(co8), .overflow(ov8)
  );

  // Carry out of bit 4j+3 for each group, as the upstream carry generator would supply.
  function automatic logic [7:0] gold_sc(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input int n);
    logic [7:0]  r;
    logic [63:0] mask, t;
    r = '0;
    for (int j = 0; j < n / 4; j++) begin
      mask = (64'd1 << (4 * j + 4)) - 64'd1;
      t    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, c};
      r[j] = t[4 * j + 4];
    end
    return r;
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {32'd0, c};
    o = (a[31] == b[31]) && (t[31] != a[31]);
    return {o, t[32], t[31:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    logic       o;
    t = {1'b0, a} + {1'b0, b} + {8'd0, c};
    o = (a[7] == b[7]) && (t[7] != a[7]);
    return {o, t[8], t[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [7:0] t8;
    op1   = a;
    op2   = b;
    cin   = c;
    sc32  = gold_sc(a, b, c, 32);
    op1_8 = a[7:0];
    op2_8 = b[7:0];
    t8    = gold_sc({24'd0, a[7:0]}, {24'd0, b[7:0]}, c, 8);
    sc8   = t8[1:0];
  endtask

  task automatic chk_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
    chk({tag, "_co"}, {63'd0, co}, {63'd0, ec});
    chk({tag, "_ov"}, {63'd0, ov}, {63'd0, eo});
  endtask

  // One cycle with random operands, scoreboarding both widths.
  task automatic rand_cycle(input logic iv, input logic ordy);
    logic [33:0] e32;
    logic [9:0]  e8;
    in_valid  = iv;
    out_ready = ordy;
    drive($urandom, $urandom, 1'($urandom_range(0, 1)));
    #1;
    if (in_valid && in_ready)  q32.push_back(ref32(op1, op2, cin));
    if (in_valid && in_ready8) q8.push_back(ref8(op1_8, op2_8, cin));
    if (out_valid && out_ready) begin
      if (q32.size() == 0) chk("rnd32_unexpected", 64'd1, 64'd0);
      else begin
        e32 = q32.pop_front();
        chk("rnd32", {30'd0, ov, co, sum}, {30'd0, e32});
      end
    end
    if (out_valid8 && out_ready) begin
      if (q8.size() == 0) chk("rnd8_unexpected", 64'd1, 64'd0);
      else begin
        e8 = q8.pop_front();
        chk("rnd8", {54'd0, ov8, co8, sum8}, {54'd0, e8});
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles
    reset = 1'b1;
    step(); step(); step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_co", {63'd0, co}, 64'd0);
    chk("rst_ov", {63'd0, ov}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Full-width carry ripple: 1 + FFFF_FFFF
    out_ready = 1'b1;
    drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
    step();
    chk_out("ripple", 32'h0000_0000, 1'b1, 1'b0);

    // Signed overflow cases, back to back
    drive(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    in_valid = 1'b1;
    step();
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    step();
    in_valid = 1'b0;
    chk_out("ovf_pos", 32'h8000_0000, 1'b0, 1'b1);
    step();
    chk_out("ovf_neg", 32'h0000_0000, 1'b1, 1'b1);
    step();
    chk("idle_after", {63'd0, out_valid}, 64'd0);

    // Stall: 6 cycles of out_ready=0 with 4 beats offered
    out_ready = 1'b0;
    drive(32'h0000_0001, 32'h0000_0002, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("stall_rdy0", {63'd0, in_ready}, 64'd1);
    step();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    #1;
    chk("stall_rdy1", {63'd0, in_ready}, 64'd1);
    step();
    drive(32'h1234_5678, 32'h1111_1111, 1'b1);
    #1;
    chk("stall_rdy2", {63'd0, in_ready}, 64'd0);
    chk_out("stall_hold0", 32'h0000_0003, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_rdy_hold", {63'd0, in_ready}, 64'd0);
      chk_out("stall_hold", 32'h0000_0003, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", {63'd0, in_ready}, 64'd1);
    chk_out("order0", 32'h0000_0003, 1'b0, 1'b0);
    step();
    chk_out("order1", 32'h0000_0000, 1'b1, 1'b0);
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step();
    in_valid = 1'b0;
    chk_out("order2", 32'h2345_678A, 1'b0, 1'b0);
    step();
    chk_out("order3", 32'h7FFF_FFFF, 1'b1, 1'b1);
    step();
    chk("order_no_dup", {63'd0, out_valid}, 64'd0);

    // Reset with both stages full discards in-flight beats
    out_ready = 1'b0;
    drive(32'h0000_0010, 32'h0000_0020, 1'b0);
    in_valid = 1'b1;
    step();
    drive(32'h0000_0030, 32'h0000_0040, 1'b0);
    step();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_sum", {32'd0, sum}, 64'd0);
    chk("mid_rst_co", {63'd0, co}, 64'd0);
    out_ready = 1'b1;
    drive(32'h0000_0005, 32'h0000_0006, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    chk("post_rst_lat1", {63'd0, out_valid}, 64'd0);
    step();
    chk_out("post_rst", 32'h0000_000B, 1'b0, 1'b0);
    step();
    chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);

    // Random handshakes at both widths
    for (int i = 0; i < 10000; i++) begin
      rand_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) rand_cycle(1'b0, 1'b1);
    chk("rnd32_drained", 64'(q32.size()), 64'd0);
    chk("rnd8_drained", 64'(q8.size()), 64'd0);

    // Full throughput with out_ready held high
    for (int i = 0; i < 60; i++) begin
      rand_cycle(1'b1, 1'b1);
      chk("thru_in_ready", {63'd0, in_ready}, 64'd1);
      if (i >= 1) chk("thru_out_valid", {63'd0, out_valid}, 64'd1);
    end
    for (int i = 0; i < 4; i++) rand_cycle(1'b0, 1'b1);
    chk("thru32_drained", 64'(q32.size()), 64'd0);
    chk("thru8_drained", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
